// File: rtl/vram_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma_pkg
// Description : Shared types for the VRAM block-transfer engine: the FSM
//               state encoding and the command opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        CRD  = 3'd2,    // copy: issue read of the source word
        CWR  = 3'd3,    // copy: write the word returned by the read
        DONE = 3'd4
    } state_t;

    localparam logic CMD_FILL = 1'b0;
    localparam logic CMD_COPY = 1'b1;

endpackage : vram_dma_pkg
`default_nettype wire

// File: rtl/vram_dma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma_addr_gen
// Description : Address generator for vram_dma. Holds the latched source and
//               destination bases, the word count, the direction and the word
//               counter. The address outputs describe the word that the NEXT
//               cycle will access, so the top level can register them straight
//               into the VRAM port:
//                 load    -> index 0 of the command on the input pins
//                 advance -> counter + 1
//                 neither -> counter
//               Descending mode maps index i to offset length-1-i.
// Ports       : clk, reset      clock, asynchronous active-high reset
//               load            accept a command (bases/length/desc_in latched)
//               advance         step the word counter
//               src_addr/dst_addr/length/desc_in  command fields
//               nxt_src/nxt_dst addresses for the upcoming access
//               nxt_dst_ok      nxt_dst lies inside the implemented VRAM
//               last            current counter value is the final word
// Revision    : 1.0 - initial release
// ============================================================================
module vram_dma_addr_gen #(
    parameter int ADDR_W = 14,
    parameter int WORDS  = 1056
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              desc_in,
    output logic [ADDR_W-1:0] nxt_src,
    output logic [ADDR_W-1:0] nxt_dst,
    output logic              nxt_dst_ok,
    output logic              last
);

    localparam logic [ADDR_W:0] c_one = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] r_src_base;
    logic [ADDR_W-1:0] r_dst_base;
    logic [ADDR_W:0]   r_len;
    logic              r_desc;
    logic [ADDR_W:0]   r_cnt;

    logic [ADDR_W-1:0] w_sbase;
    logic [ADDR_W-1:0] w_dbase;
    logic [ADDR_W:0]   w_len;
    logic              w_desc;
    logic [ADDR_W:0]   w_idx;
    logic [ADDR_W:0]   w_off;

    // On the accept cycle the latches are not loaded yet, so look through to
    // the command pins.
    assign w_sbase = load ? src_addr : r_src_base;
    assign w_dbase = load ? dst_addr : r_dst_base;
    assign w_len   = load ? length   : r_len;
    assign w_desc  = load ? desc_in  : r_desc;
    assign w_idx   = load ? '0 : (advance ? r_cnt + c_one : r_cnt);
    assign w_off   = w_desc ? (w_len - c_one - w_idx) : w_idx;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign nxt_src    = w_sbase + w_off[ADDR_W-1:0];
    assign nxt_dst    = w_dbase + w_off[ADDR_W-1:0];
    assign nxt_dst_ok = (int'(nxt_dst) < WORDS);
    assign last       = (r_cnt == r_len - c_one);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_base <= '0;
            r_dst_base <= '0;
            r_len      <= '0;
            r_desc     <= 1'b0;
            r_cnt      <= '0;
        end else if (load) begin
            r_src_base <= src_addr;
            r_dst_base <= dst_addr;
            r_len      <= length;
            r_desc     <= desc_in;
            r_cnt      <= '0;
        end else if (advance) begin
            r_cnt      <= r_cnt + c_one;
        end
    end

endmodule : vram_dma_addr_gen
`default_nettype wire

// File: rtl/vram_dma.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma
// Description : Block-transfer engine on the synchronous-read CPU port of one
//               VRAM instance. Executes one FILL or COPY command at a time and
//               pulses done on completion. FILL writes one word per cycle;
//               COPY alternates a read cycle (CRD) and a write cycle (CWR).
//               Writes to addresses >= WORDS are suppressed without changing
//               the cycle count.
// Option      : VRAM_DMA_OVERLAP_EN - when defined, a COPY whose destination
//               starts inside the source region (src < dst < src+length) runs
//               descending, giving memmove semantics. When undefined, COPY is
//               always ascending.
// Ports       : clk, reset          clock, asynchronous active-high reset
//               start, cmd          command strobe (IDLE only), 0=FILL 1=COPY
//               src_addr, dst_addr  base addresses
//               length              word count (0 allowed)
//               fill_value          FILL data word
//               busy, done          status: busy through DONE, 1-cycle done
//               vram_addr, vram_we  registered VRAM address / write enable
//               vram_d              VRAM write data
//               vram_q              VRAM read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_dma
    import vram_dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int WORDS  = 1056
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_d,
    input  logic [DATA_W-1:0] vram_q
);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_fill;

    logic              w_load;
    logic              w_advance;
    logic              w_desc_in;
    logic [ADDR_W-1:0] w_nxt_src;
    logic [ADDR_W-1:0] w_nxt_dst;
    logic              w_nxt_dst_ok;
    logic              w_last;

    assign w_load    = (r_state == IDLE) && start;
    assign w_advance = (r_state == FILL) || (r_state == CWR);

`ifdef VRAM_DMA_OVERLAP_EN
    // Forward-overlapping copy: walk from the top so source words are read
    // before they are overwritten.
    assign w_desc_in = (cmd == CMD_COPY) && (dst_addr > src_addr)
                       && ({1'b0, dst_addr} < ({1'b0, src_addr} + length));
`else
    assign w_desc_in = 1'b0;
`endif

    vram_dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .advance    (w_advance),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .desc_in    (w_desc_in),
        .nxt_src    (w_nxt_src),
        .nxt_dst    (w_nxt_dst),
        .nxt_dst_ok (w_nxt_dst_ok),
        .last       (w_last)
    );

    // Outputs are registered alongside the state change so that the address
    // and write enable line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_fill  <= '0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_fill <= fill_value;
                        r_busy <= 1'b1;
                        if (length == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (cmd == CMD_FILL) begin
                            r_state <= FILL;
                            r_addr  <= w_nxt_dst;
                            r_we    <= w_nxt_dst_ok;
                        end else begin
                            r_state <= CRD;
                            r_addr  <= w_nxt_src;
                        end
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= w_nxt_dst;
                        r_we    <= w_nxt_dst_ok;
                    end
                end
                CRD: begin
                    r_state <= CWR;
                    r_addr  <= w_nxt_dst;
                    r_we    <= w_nxt_dst_ok;
                end
                CWR: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= CRD;
                        r_addr  <= w_nxt_src;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write data: the latched fill word, or the word read back in CRD passed
    // straight through during CWR.
    always_comb begin
        vram_d = '0;
        if (r_state == FILL) begin
            vram_d = r_fill;
        end else if (r_state == CWR) begin
            vram_d = vram_q;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign vram_we   = r_we;
    assign vram_addr = r_addr;

endmodule : vram_dma
`default_nettype wire

// File: tb/tb_vram_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_dma
// Description : Self-checking bench for vram_dma. A synchronous-read VRAM
//               model is attached to the CPU port. For each command a
//               behavioural model computes every expected write (cycle,
//               address, data) and the done cycle and queues them; a monitor
//               compares each observed write / done pulse against the queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_dma;

    localparam int DW    = 32;
    localparam int AW    = 14;
    localparam int WORDS = 1056;
    localparam int AMOD  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cmd;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          done;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_d;
    logic [DW-1:0] vram_q;

    vram_dma #(.DATA_W(DW), .ADDR_W(AW), .WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cmd        (cmd),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_d     (vram_d),
        .vram_q     (vram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM environment: synchronous read, out-of-range reads return 0.
    logic [DW-1:0] mem [WORDS];
    logic          clr    = 1'b0;
    logic          pl_en  = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (vram_we && int'(vram_addr) < WORDS) begin
            mem[vram_addr] <= vram_d;
        end
        vram_q <= (int'(vram_addr) < WORDS) ? mem[vram_addr] : '0;
    end

    // Reference state and scoreboard queues.
    typedef struct {
        int            c;
        int            a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] ref_mem [WORDS];
    wr_t           wq[$];
    int            dq[$];
    int            checks = 0;
    int            errors = 0;
    int            bz_lo  = -1;
    int            bz_hi  = -2;

    // Monitor: busy window every cycle, each write and each done pulse.
    always @(negedge clk) begin
        wr_t e;
        int  dc;
        checks++;
        if (busy !== (cyc >= bz_lo && cyc <= bz_hi)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, (cyc >= bz_lo && cyc <= bz_hi));
        end
        if (vram_we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write unexpected cyc=%0d addr=%0d data=%h", cyc, vram_addr, vram_d);
            end else begin
                e = wq.pop_front();
                if (e.c != cyc || int'(vram_addr) != e.a || vram_d !== e.d) begin
                    errors++;
                    $display("FAIL write got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                             cyc, vram_addr, vram_d, e.c, e.a, e.d);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done unexpected cyc=%0d", cyc);
            end else begin
                dc = dq.pop_front();
                if (dc != cyc) begin
                    errors++;
                    $display("FAIL done got cyc=%0d expected cyc=%0d", cyc, dc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic preload(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one command, queue its expected effects, wait for completion.
    task automatic run_cmd(input logic c, input int s, input int d, input int n,
                           input logic [DW-1:0] f, input logic inj);
        int            a, nend, idx, sa, da;
        logic          desc;
        logic [DW-1:0] v;
        wr_t           e;
        @(negedge clk);
        start = 1'b1; cmd = c; src_addr = AW'(s); dst_addr = AW'(d);
        length = (AW+1)'(n); fill_value = f;
        a    = cyc + 1;
        desc = 1'b0;
`ifdef VRAM_DMA_OVERLAP_EN
        desc = c && (d > s) && (d < s + n);
`endif
        nend = (n == 0) ? 0 : (c ? 2 * n : n);
        for (int k = 0; k < n; k++) begin
            idx = desc ? (n - 1 - k) : k;
            da  = (d + idx) % AMOD;
            sa  = (s + idx) % AMOD;
            if (!c) v = f;
            else    v = (sa < WORDS) ? ref_mem[sa] : '0;
            if (da < WORDS) begin
                e.c = c ? (a + 2 * k + 1) : (a + k);
                e.a = da;
                e.d = v;
                wq.push_back(e);
                ref_mem[da] = v;
            end
        end
        dq.push_back(a + nend);
        bz_lo = a;
        bz_hi = a + nend;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < nend + 8 && dq.size() != 0; t++) begin
            // A strobe in the middle of a running command must be ignored.
            if (t == 2 && nend >= 8 && inj) begin
                start = 1'b1; cmd = ~c; dst_addr = AW'($urandom); length = 5;
            end
            if (t == 3) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL done_timeout got=pending expected=done_by_cyc%0d", a + nend);
            dq.delete();
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL writes_missing got=%0d_pending expected=0", wq.size());
            wq.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int            a, s, d, n, sel, bad;
        logic [DW-1:0] fv, old9;
        reset = 1'b1; start = 1'b0; cmd = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_we", DW'(vram_we), '0);
        chk("rst_addr", DW'(vram_addr), '0);
        chk("rst_d", vram_d, '0);
        @(negedge clk);
        reset = 1'b0;

        // FILL 4 words of DEADBEEF at 0x010.
        run_cmd(1'b0, 0, 'h010, 4, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 4; i++) chk("fill_readback", mem['h010 + i], 32'hDEADBEEF);

        // COPY 1,2,3 from 0x000 to 0x100.
        preload(0, 1); preload(1, 2); preload(2, 3);
        run_cmd(1'b1, 0, 'h100, 3, '0, 1'b0);
        for (int i = 0; i < 3; i++) chk("copy_dst", mem['h100 + i], DW'(i + 1));
        for (int i = 0; i < 3; i++) chk("copy_src", mem[i], DW'(i + 1));

        // Zero-length and end-of-VRAM fills.
        run_cmd(1'b0, 0, 'h200, 0, 32'h11111111, 1'b0);
        run_cmd(1'b0, 0, WORDS - 2, 4, 32'hCAFEF00D, 1'b0);
        chk("edge_1054", mem[WORDS-2], 32'hCAFEF00D);
        chk("edge_1055", mem[WORDS-1], 32'hCAFEF00D);

        // Forward-overlapping copy.
        preload(0, 1); preload(1, 2); preload(2, 3); preload(3, 4);
        run_cmd(1'b1, 0, 1, 4, '0, 1'b0);
`ifdef VRAM_DMA_OVERLAP_EN
        for (int i = 0; i < 4; i++) chk("overlap_memmove", mem[1 + i], DW'(i + 1));
`else
        for (int i = 0; i < 4; i++) chk("overlap_replicate", mem[1 + i], DW'(1));
`endif

        // Randomized commands.
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 3));
            s   = int'($urandom_range(0, WORDS - 1));
            n   = int'($urandom_range(0, 12));
            case (sel)
                0:       d = WORDS - int'($urandom_range(1, 6));
                1:       d = int'($urandom_range(0, WORDS - 1));
                2:       d = AMOD - int'($urandom_range(1, 4));
                default: d = (s + int'($urandom_range(0, 4))) % AMOD;
            endcase
            fv = $urandom;
            run_cmd(1'($urandom_range(0, 1)), s, d, n, fv, 1'($urandom_range(0, 1)));
        end

        // Reset in cycle 10 of a 100-word FILL at 0; stray start in cycle 5.
        preload(9, 32'h12345678);
        old9 = ref_mem[9];
        @(negedge clk);
        start = 1'b1; cmd = 1'b0; dst_addr = '0; length = 100; fill_value = 32'hA5A50F0F;
        a = cyc + 1;
        for (int k = 0; k < 9; k++) begin
            wq.push_back('{c: a + k, a: k, d: 32'hA5A50F0F});
            ref_mem[k] = 32'hA5A50F0F;
        end
        bz_lo = a;
        bz_hi = a + 8;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; cmd = 1'b1; src_addr = 'h300; dst_addr = 'h20; length = 3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_we", DW'(vram_we), '0);
        chk("rst_mid_busy", DW'(busy), '0);
        chk("rst_mid_done", DW'(done), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_writes_seen", DW'(wq.size()), '0);
        chk("rst_word8", mem[8], 32'hA5A50F0F);
        chk("rst_word9", mem[9], old9);

        // Whole-memory comparison against the reference image.
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (bad == 0) $display("FAIL mem_image addr=%0d got=%h expected=%h", i, mem[i], ref_mem[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vram_dma
`default_nettype wire
